// File: rtl/filter_out_fifo.sv
// Output buffer behind the polyphase IIR filter: drops the start-up transient, then FWFT FIFO with valid/ready drain.
// Optional clip statistics (clip_cnt port) enabled by defining FILT_OUT_CLIP_STATS_EN.
module filter_out_fifo #(
   parameter int DEPTH        = 16,
   parameter int SKIP_SAMPLES = 24
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic [10:0]              s_data,
   output logic [10:0]              m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     warm_done,
   output logic                     overflow,
   input  logic                     clr_ovf
`ifdef FILT_OUT_CLIP_STATS_EN
   ,
   output logic [15:0]              clip_cnt
`endif
);

   // state  | meaning
   // WARMUP | discarding filter start-up samples
   // RUN    | every en cycle is a push; left only through reset

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int SW = (SKIP_SAMPLES > 1) ? $clog2(SKIP_SAMPLES) : 1;
   localparam logic [SW-1:0] SKIP_LAST = (SKIP_SAMPLES > 0) ? SW'(SKIP_SAMPLES - 1) : '0;
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

   typedef enum logic {WARMUP, RUN} state_t;
   localparam state_t RST_STATE = (SKIP_SAMPLES == 0) ? RUN : WARMUP;

   state_t          state, state_n;
   logic [SW-1:0]   skip_cnt;
   logic [10:0]     mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
   logic [LW-1:0]   level_n;
   logic [10:0]     head_n;
   logic            push, pop, full, wr_en;

   always_ff @(posedge clk) begin
      if (reset) state <= RST_STATE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (state == WARMUP && en && skip_cnt == SKIP_LAST) state_n = RUN;
   end

   assign warm_done = (state == RUN);
   assign push      = (state == RUN) && en;
   assign pop       = m_valid && m_ready;
   assign full      = (level == FULL_LVL);
   assign wr_en     = push && (!full || pop);
   assign rd_ptr_n  = pop ? rd_ptr + PW'(1) : rd_ptr;
   assign level_n   = level + LW'(wr_en) - LW'(pop);

   // The next head may be the slot written this very cycle (empty FIFO, or last entry being popped).
   assign head_n = (wr_en && wr_ptr == rd_ptr_n) ? s_data : mem[rd_ptr_n];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         skip_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         overflow <= 1'b0;
      end else begin
         if (state == WARMUP && en) skip_cnt <= skip_cnt + SW'(1);
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         rd_ptr  <= rd_ptr_n;
         level   <= level_n;
         m_valid <= (level_n != '0);
         if (level_n != '0) m_data <= head_n;
         if (push && full && !pop) overflow <= 1'b1;
         else if (clr_ovf)         overflow <= 1'b0;
      end
   end

`ifdef FILT_OUT_CLIP_STATS_EN
   logic is_clip;
   assign is_clip = (s_data == 11'h3FF) || (s_data == 11'h400);

   always_ff @(posedge clk) begin
      if (reset)
         clip_cnt <= '0;
      else if (push && is_clip && clip_cnt != 16'hFFFF)
         clip_cnt <= clip_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_filter_out_fifo.sv
// Directed bench for filter_out_fifo: table-driven FIFO vectors plus warm-up, full, overflow and reset sequences.
module tb_filter_out_fifo;

   logic               clk = 1'b0;
   logic               reset;
   logic               en;
   logic signed [10:0] s_data;
   logic signed [10:0] m_data;
   logic               m_valid;
   logic               m_ready;
   logic [4:0]         level;
   logic               warm_done;
   logic               overflow;
   logic               clr_ovf;
`ifdef FILT_OUT_CLIP_STATS_EN
   logic [15:0]        clip_cnt;
`endif

   int n_pass = 0;
   int n_total = 0;

   filter_out_fifo #(.DEPTH(16), .SKIP_SAMPLES(24)) dut (
      .clk(clk), .reset(reset), .en(en), .s_data(s_data),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .level(level), .warm_done(warm_done), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef FILT_OUT_CLIP_STATS_EN
      , .clip_cnt(clip_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic en;
      int   d;
      logic rdy;
      logic exp_v;
      int   exp_d;
      int   exp_l;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // inputs are changed 1 time unit after the edge; outputs are sampled at that same point
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input int d, input logic r, input logic c);
      en      = e;
      s_data  = 11'(d);
      m_ready = r;
      clr_ovf = c;
   endtask

   initial begin
      tbl[0] = '{1'b1,    5, 1'b1, 1'b1,    5, 1};
      tbl[1] = '{1'b1,   -7, 1'b1, 1'b1,   -7, 1};
      tbl[2] = '{1'b1,  100, 1'b1, 1'b1,  100, 1};
      tbl[3] = '{1'b0,    0, 1'b1, 1'b0,  100, 0};
      tbl[4] = '{1'b0,    0, 1'b1, 1'b0,  100, 0};
      tbl[5] = '{1'b1, -1023, 1'b0, 1'b1, -1023, 1};
      tbl[6] = '{1'b1, 1022, 1'b0, 1'b1, -1023, 2};
      tbl[7] = '{1'b0,    0, 1'b0, 1'b1, -1023, 2};
      tbl[8] = '{1'b0,    0, 1'b1, 1'b1, 1022, 1};
      tbl[9] = '{1'b0,    0, 1'b1, 1'b0, 1022, 0};

      reset = 1'b1;
      drive(1'b0, 0, 1'b0, 1'b0);
      step();
      step();
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_warm_done", int'(warm_done), 0);
`ifdef FILT_OUT_CLIP_STATS_EN
      chk("rst_clip_cnt", int'(clip_cnt), 0);
`endif
      reset = 1'b0;

      // T1: samples 1..24 discarded, 25 is the first stored
      for (int i = 1; i <= 24; i++) begin
         drive(1'b1, i, 1'b1, 1'b0);
         step();
         chk($sformatf("warm_level_%0d", i), int'(level), 0);
         chk($sformatf("warm_done_%0d", i), int'(warm_done), (i == 24) ? 1 : 0);
      end
      drive(1'b1, 25, 1'b1, 1'b0);
      step();
      chk("first_m_valid", int'(m_valid), 1);
      chk("first_m_data", int'(m_data), 25);
      chk("first_level", int'(level), 1);
      drive(1'b0, 0, 1'b1, 1'b0);
      step();
      chk("first_drain_valid", int'(m_valid), 0);
      chk("first_drain_level", int'(level), 0);
      chk("first_hold_data", int'(m_data), 25);

      // T2 and stall patterns from the table
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].en, tbl[i].d, tbl[i].rdy, 1'b0);
         step();
         chk($sformatf("tbl%0d_m_valid", i), int'(m_valid), int'(tbl[i].exp_v));
         chk($sformatf("tbl%0d_m_data", i), int'(m_data), tbl[i].exp_d);
         chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].exp_l);
         chk($sformatf("tbl%0d_overflow", i), int'(overflow), 0);
      end

      // fill to 16 without draining
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 200 + i, 1'b0, 1'b0);
         step();
         chk($sformatf("fill_level_%0d", i), int'(level), i + 1);
         chk($sformatf("fill_head_%0d", i), int'(m_data), 200);
      end
      chk("fill_overflow", int'(overflow), 0);

      // T4: push and pop while full
      drive(1'b1, 216, 1'b1, 1'b0);
      step();
      chk("fullpp_level", int'(level), 16);
      chk("fullpp_overflow", int'(overflow), 0);
      chk("fullpp_head", int'(m_data), 201);

      // T3: push while full and not popping -> dropped
      drive(1'b1, 217, 1'b0, 1'b0);
      step();
      chk("ovf_level", int'(level), 16);
      chk("ovf_overflow", int'(overflow), 1);
      chk("ovf_head", int'(m_data), 201);

      for (int k = 0; k < 16; k++) begin
         drive(1'b0, 0, 1'b1, 1'b0);
         step();
         chk($sformatf("drain_level_%0d", k), int'(level), 15 - k);
         chk($sformatf("drain_valid_%0d", k), int'(m_valid), (k < 15) ? 1 : 0);
         chk($sformatf("drain_data_%0d", k), int'(m_data), (k < 15) ? 202 + k : 216);
      end
      chk("drain_overflow_sticky", int'(overflow), 1);

      // T5: clear colliding with a new overflow, then clear alone
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i, 1'b0, 1'b0);
         step();
      end
      chk("t5_level", int'(level), 16);
      drive(1'b1, 99, 1'b0, 1'b1);
      step();
      chk("t5_set_wins", int'(overflow), 1);
      chk("t5_level_after", int'(level), 16);
      drive(1'b0, 0, 1'b0, 1'b1);
      step();
      chk("t5_clear", int'(overflow), 0);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 0, 1'b1, 1'b0);
         step();
      end
      chk("t5_drained_level", int'(level), 0);
      chk("t5_last_data", int'(m_data), 15);

      // T6: clip statistics, then reset mid-stream
      drive(1'b1, 1023, 1'b0, 1'b0);
      step();
      drive(1'b1, -1024, 1'b0, 1'b0);
      step();
      drive(1'b1, 0, 1'b0, 1'b0);
      step();
      drive(1'b1, -1023, 1'b0, 1'b0);
      step();
      chk("t6_level", int'(level), 4);
      chk("t6_head", int'(m_data), 1023);
`ifdef FILT_OUT_CLIP_STATS_EN
      chk("t6_clip_cnt", int'(clip_cnt), 2);
`endif
      reset = 1'b1;
      drive(1'b1, 7, 1'b0, 1'b0);
      step();
      chk("t6_rst_valid", int'(m_valid), 0);
      chk("t6_rst_level", int'(level), 0);
      chk("t6_rst_data", int'(m_data), 0);
      chk("t6_rst_warm", int'(warm_done), 0);
`ifdef FILT_OUT_CLIP_STATS_EN
      chk("t6_rst_clip", int'(clip_cnt), 0);
`endif
      reset = 1'b0;
      drive(1'b1, 1023, 1'b1, 1'b0);
      step();
      chk("t6_rewarm_level", int'(level), 0);
      chk("t6_rewarm_valid", int'(m_valid), 0);
      chk("t6_rewarm_done", int'(warm_done), 0);
`ifdef FILT_OUT_CLIP_STATS_EN
      chk("t6_rewarm_clip", int'(clip_cnt), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
